// File: rtl/frame_writer_if.sv
// Pixel ingress from the filter and the raster-order egress stream of the frame writer.
interface frame_writer_if;
  logic       mem_write_en;
  logic [7:0] bus_out;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  // Side that feeds pixels in and drains the frame (filter + downstream sink).
  modport master (
    output mem_write_en, bus_out, out_ready,
    input  out_valid, out_data, out_last
  );

  // The frame writer itself.
  modport slave (
    input  mem_write_en, bus_out, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/frame_writer.sv
// Frame writer: border-fills a frame buffer, collects the filter's interior
// pixels into it, then streams the whole frame out in raster order.
//
//  state   | meaning
//  S_IDLE  | waiting for start
//  S_CLEAR | writing BORDER_VAL to every address, one per cycle
//  S_WRITE | storing interior pixels as mem_write_en arrives
//  S_DUMP  | reading the frame out over valid/ready
//  S_DONE  | one-cycle frame_done pulse, then back to idle
module frame_writer #(
  parameter int         IMG_W      = 256,
  parameter int         IMG_H      = 256,
  parameter int         AW         = 16,
  parameter logic [7:0] BORDER_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  frame_writer_if.slave      bus,
  output logic               busy,
  output logic               frame_done,
  output logic               err_drop
);

  localparam int             NPIX      = IMG_W * IMG_H;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0]  COL_LAST  = AW'(IMG_W - 3);
  localparam logic [AW-1:0]  ROW_LAST  = AW'(IMG_H - 3);
  localparam logic [AW-1:0]  WR_FIRST  = AW'(IMG_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WRITE, S_DUMP, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] addr;      // clear address, then read address during dump
  logic [AW-1:0] wr_addr;   // tracks (row+1)*IMG_W + col+1 by increments only
  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic          rd_all;    // every address of the frame has been issued
  logic          pend;      // rd_data holds a freshly read pixel this cycle
  logic          pend_last;
  logic          head_valid;
  logic [7:0]    head_data;
  logic          head_last;
  logic          skid_valid;
  logic [7:0]    skid_data;
  logic          skid_last;

  logic [7:0]    mem [NPIX];
  logic [7:0]    rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          pop;
  logic [1:0]    occ;
  logic          rd_issue;

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.out_last  = head_last;

  // Single write port shared by the border clear and the pixel store.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr;
    ram_wdata = BORDER_VAL;
    if (state == S_CLEAR) begin
      ram_we = 1'b1;
    end else if (state == S_WRITE) begin
      ram_we    = bus.mem_write_en;
      ram_waddr = wr_addr;
      ram_wdata = bus.bus_out;
    end
  end

  // Issue a read only if its data is guaranteed a slot (head or skid) on arrival.
  always_comb begin
    pop      = head_valid & bus.out_ready;
    occ      = {1'b0, head_valid} + {1'b0, skid_valid} + {1'b0, pend} - {1'b0, pop};
    rd_issue = (state == S_DUMP) && !rd_all && (occ < 2'd2);
  end

  // Frame buffer: one write, one synchronous read per cycle; contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_data <= mem[addr];
  end

  // Sequencer, write/read counters and the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      wr_addr    <= '0;
      col        <= '0;
      row        <= '0;
      rd_all     <= 1'b0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      head_valid <= 1'b0;
      head_data  <= '0;
      head_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pend       <= rd_issue;
      pend_last  <= rd_issue && (addr == LAST_ADDR);
      if (bus.mem_write_en && state != S_WRITE) err_drop <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CLEAR;
            busy     <= 1'b1;
            err_drop <= 1'b0;
            addr     <= '0;
          end
        end

        S_CLEAR: begin
          if (addr == LAST_ADDR) begin
            state   <= S_WRITE;
            addr    <= '0;
            col     <= '0;
            row     <= '0;
            wr_addr <= WR_FIRST;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        S_WRITE: begin
          if (bus.mem_write_en) begin
            if (col == COL_LAST) begin
              col     <= '0;
              wr_addr <= wr_addr + AW'(3);
              if (row == ROW_LAST) begin
                state  <= S_DUMP;
                addr   <= '0;
                rd_all <= 1'b0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col     <= col + 1'b1;
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end

        S_DUMP: begin
          if (rd_issue) begin
            if (addr == LAST_ADDR) rd_all <= 1'b1;
            else                   addr   <= addr + 1'b1;
          end
          if (pop || !head_valid) begin
            if (skid_valid) begin
              head_valid <= 1'b1;
              head_data  <= skid_data;
              head_last  <= skid_last;
              skid_valid <= pend;
              skid_data  <= rd_data;
              skid_last  <= pend_last;
            end else if (pend) begin
              head_valid <= 1'b1;
              head_data  <= rd_data;
              head_last  <= pend_last;
            end else begin
              head_valid <= 1'b0;
              head_last  <= 1'b0;
            end
          end else if (pend) begin
            skid_valid <= 1'b1;
            skid_data  <= rd_data;
            skid_last  <= pend_last;
          end
          if (pop && head_last) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
            head_valid <= 1'b0;
            head_last  <= 1'b0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: two instances (border 00 and FF) driven in lockstep,
// each checked against a frame image computed from the pixels sent.
module tb_frame_writer;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_we = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic       rdy = 1'b1;

  logic [1:0] busy;
  logic [1:0] fdone;
  logic [1:0] err;
  logic [1:0] ov;
  logic [1:0] ol;
  logic [7:0] od [2];
  logic [7:0] border [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  frame_writer_if bus0();
  frame_writer_if bus1();

  assign bus0.mem_write_en = mem_we;
  assign bus0.bus_out      = pix_in;
  assign bus0.out_ready    = rdy;
  assign bus1.mem_write_en = mem_we;
  assign bus1.bus_out      = pix_in;
  assign bus1.out_ready    = rdy;

  assign ov    = {bus1.out_valid, bus0.out_valid};
  assign ol    = {bus1.out_last, bus0.out_last};
  assign od[0] = bus0.out_data;
  assign od[1] = bus1.out_data;

  frame_writer #(.IMG_W(W), .IMG_H(H), .AW(4), .BORDER_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(bus0),
    .busy(busy[0]), .frame_done(fdone[0]), .err_drop(err[0])
  );

  frame_writer #(.IMG_W(W), .IMG_H(H), .AW(4), .BORDER_VAL(8'hFF)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .busy(busy[1]), .frame_done(fdone[1]), .err_drop(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected frame: border everywhere except the interior, which holds the
  // pixels in arrival order.
  function automatic logic [7:0] exp_px(input logic [31:0] pw, input int idx, input logic [7:0] b);
    int r, c;
    r = idx / W;
    c = idx % W;
    if (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2)
      return pw[8 * ((r - 1) * (W - 2) + (c - 1)) +: 8];
    return b;
  endfunction

  function automatic logic [31:0] rand_pw();
    logic [31:0] pw;
    logic [7:0]  v;
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom_range(1, 254));
      if (v == 8'hAA) v = 8'h55;
      pw[8 * k +: 8] = v;
    end
    return pw;
  endfunction

  task automatic stray_idle();
    @(negedge clk);
    mem_we = 1'b1;
    pix_in = 8'hAA;
    @(negedge clk);
    mem_we = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stray_idle_err%0d", d), err[d], 1);
      chk($sformatf("stray_idle_busy%0d", d), busy[d], 0);
    end
  endtask

  // rmode: 0 ready held high, 1 toggling, 2 random. abort_at>0 resets after that many beats.
  task automatic do_frame(input logic [31:0] pw, input int gap, input int rmode,
                          input bit stray, input bit start_mid, input int abort_at);
    int beats [2];
    int first_v [2];
    int cyc;
    @(negedge clk);
    start  = 1'b1;
    mem_we = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("start_busy%0d", d), busy[d], 1);
      chk($sformatf("start_err_clr%0d", d), err[d], 0);
    end
    for (int i = 1; i <= N; i++) begin
      start  = 1'b0;
      mem_we = stray && (i == 5);
      pix_in = 8'hAA;
      @(negedge clk);
    end
    mem_we = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("clear_err%0d", d), err[d], 32'(stray));
    for (int k = 0; k < 4; k++) begin
      repeat (gap) begin
        mem_we = 1'b0;
        @(negedge clk);
      end
      mem_we = 1'b1;
      pix_in = pw[8 * k +: 8];
      start  = start_mid && (k == 1);
      @(negedge clk);
      start = 1'b0;
    end
    mem_we  = 1'b0;
    beats   = '{0, 0};
    first_v = '{-1, -1};
    cyc     = 0;
    while ((beats[0] < N || beats[1] < N) && cyc < 300) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if (first_v[d] < 0) first_v[d] = cyc;
          if (beats[d] >= N) begin
            chk($sformatf("extra_beat%0d", d), ov[d], 0);
          end else begin
            chk($sformatf("data%0d[%0d]", d, beats[d]), od[d], exp_px(pw, beats[d], border[d]));
            chk($sformatf("last%0d[%0d]", d, beats[d]), ol[d], 32'(beats[d] == N - 1));
            if (rdy) beats[d]++;
          end
        end
      end
      if (abort_at > 0 && beats[0] == abort_at) begin
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("abort_busy%0d", d), busy[d], 0);
          chk($sformatf("abort_valid%0d", d), ov[d], 0);
          chk($sformatf("abort_err%0d", d), err[d], 0);
        end
        repeat (3) begin
          @(negedge clk);
          for (int d = 0; d < 2; d++) chk($sformatf("post_abort_valid%0d", d), ov[d], 0);
        end
        return;
      end
      @(negedge clk);
      cyc++;
    end
    rdy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dump_beats%0d", d), beats[d], N);
      chk($sformatf("first_valid_lat%0d", d), (first_v[d] >= 0 && first_v[d] <= 2), 1);
      chk($sformatf("done_pulse%0d", d), fdone[d], 1);
      chk($sformatf("done_valid%0d", d), ov[d], 0);
      chk($sformatf("done_busy%0d", d), busy[d], 1);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("done_pulse_end%0d", d), fdone[d], 0);
      chk($sformatf("idle_busy%0d", d), busy[d], 0);
      chk($sformatf("end_err%0d", d), err[d], 32'(stray));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    border[0] = 8'h00;
    border[1] = 8'hFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy%0d", d), busy[d], 0);
      chk($sformatf("rst_valid%0d", d), ov[d], 0);
      chk($sformatf("rst_last%0d", d), ol[d], 0);
      chk($sformatf("rst_done%0d", d), fdone[d], 0);
      chk($sformatf("rst_err%0d", d), err[d], 0);
    end

    do_frame(32'h44332211, 0, 0, 1'b0, 1'b0, 0);   // full frame
    do_frame(32'h44332211, 0, 1, 1'b0, 1'b0, 0);   // toggling backpressure
    do_frame(32'h44332211, 3, 0, 1'b0, 1'b0, 0);   // gapped input
    stray_idle();
    do_frame(rand_pw(), 0, 0, 1'b1, 1'b0, 0);      // stray in idle and clear
    do_frame(rand_pw(), 1, 2, 1'b0, 1'b0, 0);      // err_drop cleared by start
    do_frame(rand_pw(), 0, 0, 1'b0, 1'b0, 6);      // reset mid-dump
    do_frame(32'h44332211, 0, 0, 1'b0, 1'b0, 0);   // clean frame after abort
    do_frame(rand_pw(), 1, 0, 1'b0, 1'b1, 0);      // start during write
    for (int i = 0; i < 6; i++)
      do_frame(rand_pw(), int'($urandom_range(0, 3)), 2, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
